// File: rtl/mem_responder.sv
// mem_responder: wait-stated word memory behind the multicycle core's unified bus.
// It serves one request at a time. MemReady is a one-cycle completion pulse, and MemErr is only meaningful alongside it.
module mem_responder #(
    parameter int ADDR_WIDTH = 6,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReq,
    input  logic                  MemWrite,
    input  logic [31:0]           Adr,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  MemReady,
    output logic                  MemErr,
    input  logic                  InitWe,
    input  logic [ADDR_WIDTH-1:0] InitAdr,
    input  logic [31:0]           InitData
);
    // state | meaning
    // IDLE  | waiting for MemReq; init port writes accepted here only
    // BUSY  | wait counter running down; access at terminal count
    // DONE  | MemReady pulse, MemErr valid, unconditional return to IDLE

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q;
    logic [31:0]           adr_q;
    logic [31:0]           wdata_q;
    logic                  write_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  access;
    logic                  init_wr;
    logic                  adr_bad;
    logic [ADDR_WIDTH-1:0] index;

    assign index   = adr_q[ADDR_WIDTH+1:2];
    assign adr_bad = (adr_q[1:0] != 2'b00) || ((adr_q >> (ADDR_WIDTH + 2)) != 32'd0);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        access  = 1'b0;
        init_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemReq) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end else if (InitWe) begin
                    init_wr = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= WAIT_LOAD;
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (access) begin
                err_q <= adr_bad;
                if (!write_q) begin
                    rdata_q <= adr_bad ? 32'd0 : mem[index];
                end
            end else if (state_q == DONE) begin
                err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            adr_q   <= Adr;
            wdata_q <= WriteData;
            write_q <= MemWrite;
        end
    end

    // The array has no reset. The reset gate keeps a transaction that is aborted in BUSY from writing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_wr) begin
                mem[InitAdr] <= InitData;
            end else if (access && write_q && !adr_bad) begin
                mem[index] <= wdata_q;
            end
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = (state_q == DONE);
    assign MemErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2 and LATENCY=0) checked against an
// array-level reference of the word store and the expected response timing.
module tb_mem_responder;
    localparam int AW = 6;
    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          rst      [2];
    logic          req      [2];
    logic          we       [2];
    logic [31:0]   adr      [2];
    logic [31:0]   wdata    [2];
    logic [31:0]   rdata    [2];
    logic          rdy      [2];
    logic          merr     [2];
    logic          init_we  [2];
    logic [AW-1:0] init_adr [2];
    logic [31:0]   init_data[2];

    logic [31:0]   mdl     [2][NW];
    logic [31:0]   last_rd [2];
    int            lat     [2];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(rst[0]), .MemReq(req[0]), .MemWrite(we[0]), .Adr(adr[0]),
        .WriteData(wdata[0]), .ReadData(rdata[0]), .MemReady(rdy[0]), .MemErr(merr[0]),
        .InitWe(init_we[0]), .InitAdr(init_adr[0]), .InitData(init_data[0])
    );

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(rst[1]), .MemReq(req[1]), .MemWrite(we[1]), .Adr(adr[1]),
        .WriteData(wdata[1]), .ReadData(rdata[1]), .MemReady(rdy[1]), .MemErr(merr[1]),
        .InitWe(init_we[1]), .InitAdr(init_adr[1]), .InitData(init_data[1])
    );

    // Expected outcome of one access, from the address rules alone.
    function automatic void model_access(input int d, input bit wr, input logic [31:0] a,
                                         input logic [31:0] wd, output logic e_err,
                                         output logic [31:0] e_rd);
        int idx;
        e_err = (a % 4 != 0) || (a >= 32'(4 * NW));
        idx   = int'((a / 4) % NW);
        if (!e_err) begin
            if (wr) mdl[d][idx] = wd;
            else    last_rd[d]  = mdl[d][idx];
        end else if (!wr) begin
            last_rd[d] = 32'd0;
        end
        e_rd = last_rd[d];
    endfunction

    task automatic init_write(input int d, input int idx, input logic [31:0] data);
        @(negedge clk);
        init_we[d]   = 1'b1;
        init_adr[d]  = AW'(idx);
        init_data[d] = data;
        @(negedge clk);
        init_we[d]   = 1'b0;
        mdl[d][idx]  = data;
    endtask

    // Issue one request. cyc counts the negedges from the accept edge to the first MemReady sample.
    task automatic run_txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input bit with_init, input int iidx, input logic [31:0] idata,
                           output int cyc, output logic err, output logic [31:0] rd);
        @(negedge clk);
        req[d]   = 1'b1;
        we[d]    = wr;
        adr[d]   = a;
        wdata[d] = wd;
        if (with_init) begin
            init_we[d]   = 1'b1;
            init_adr[d]  = AW'(iidx);
            init_data[d] = idata;
        end
        @(negedge clk);
        req[d]     = 1'b0;
        init_we[d] = 1'b0;
        we[d]      = 1'($urandom);
        adr[d]     = $urandom;
        wdata[d]   = $urandom;
        cyc = 1;
        while (rdy[d] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        err = merr[d];
        rd  = rdata[d];
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready dut%0d got=%b want=0", d, rdy[d]);
            end
            checks++;
            if (merr[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_err dut%0d got=%b want=0", d, merr[d]);
            end
            checks++;
            if (rdata[d] !== 32'd0) begin
                failures++;
                $display("FAIL reset_rdata dut%0d got=%h want=0", d, rdata[d]);
            end
            rst[d]     = 1'b0;
            last_rd[d] = 32'd0;
        end
    endtask

    task automatic preload();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NW; i++)
                init_write(d, i, $urandom);
    endtask

    task automatic test_write_read();
        int          cyc;
        logic        err, e_err;
        logic [31:0] rd, e_rd;
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, 32'd0, cyc, err, rd);
        model_access(0, 1'b1, 32'h10, 32'hDEADBEEF, e_err, e_rd);
        checks++;
        if (cyc != lat[0] + 2) begin
            failures++;
            $display("FAIL wr_latency got=%0d want=%0d", cyc, lat[0] + 2);
        end
        checks++;
        if (err !== 1'b0 || rd !== e_rd) begin
            failures++;
            $display("FAIL wr_resp err=%b rd=%h want err=0 rd=%h", err, rd, e_rd);
        end
        run_txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 0, 32'd0, cyc, err, rd);
        model_access(0, 1'b0, 32'h10, 32'h0, e_err, e_rd);
        checks++;
        if (cyc != lat[0] + 2) begin
            failures++;
            $display("FAIL rd_latency got=%0d want=%0d", cyc, lat[0] + 2);
        end
        checks++;
        if (err !== 1'b0 || rd !== 32'hDEADBEEF || e_rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_data err=%b rd=%h want err=0 rd=deadbeef", err, rd);
        end
    endtask

    task automatic test_latency0();
        int          cyc;
        logic        err, e_err;
        logic [31:0] rd, e_rd;
        init_write(1, 5, 32'h12345678);
        run_txn(1, 1'b0, 32'h14, 32'h0, 1'b0, 0, 32'd0, cyc, err, rd);
        model_access(1, 1'b0, 32'h14, 32'h0, e_err, e_rd);
        checks++;
        if (cyc != 2) begin
            failures++;
            $display("FAIL lat0_latency got=%0d want=2", cyc);
        end
        checks++;
        if (err !== 1'b0 || rd !== 32'h12345678) begin
            failures++;
            $display("FAIL lat0_data err=%b rd=%h want err=0 rd=12345678", err, rd);
        end
    endtask

    task automatic test_errors();
        int          cyc;
        logic        err, e_err;
        logic [31:0] rd, e_rd;
        run_txn(0, 1'b0, 32'h11, 32'h0, 1'b0, 0, 32'd0, cyc, err, rd);
        model_access(0, 1'b0, 32'h11, 32'h0, e_err, e_rd);
        checks++;
        if (cyc != lat[0] + 2 || err !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL misaligned_rd cyc=%0d err=%b rd=%h want cyc=%0d err=1 rd=0",
                     cyc, err, rd, lat[0] + 2);
        end
        run_txn(0, 1'b1, 32'h100, 32'hCAFEF00D, 1'b0, 0, 32'd0, cyc, err, rd);
        model_access(0, 1'b1, 32'h100, 32'hCAFEF00D, e_err, e_rd);
        checks++;
        if (cyc != lat[0] + 2 || err !== 1'b1 || rd !== e_rd) begin
            failures++;
            $display("FAIL oor_wr cyc=%0d err=%b rd=%h want cyc=%0d err=1 rd=%h",
                     cyc, err, rd, lat[0] + 2, e_rd);
        end
        run_txn(0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 32'd0, cyc, err, rd);
        model_access(0, 1'b0, 32'h0, 32'h0, e_err, e_rd);
        checks++;
        if (err !== 1'b0 || rd !== e_rd) begin
            failures++;
            $display("FAIL oor_word0 err=%b rd=%h want err=0 rd=%h", err, rd, e_rd);
        end
        @(negedge clk);
        checks++;
        if (merr[0] !== 1'b0 || rdy[0] !== 1'b0) begin
            failures++;
            $display("FAIL err_clear err=%b ready=%b want both 0", merr[0], rdy[0]);
        end
    endtask

    task automatic test_reset_abort();
        int          cyc;
        bit          seen;
        logic        err, e_err;
        logic [31:0] rd, e_rd;
        @(negedge clk);
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        adr[0]   = 32'h8;
        wdata[0] = 32'hA5A5A5A5;
        @(negedge clk);
        req[0] = 1'b0;
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0]     = 1'b0;
        last_rd[0] = 32'd0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rdy[0] === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_ready got=1 want=0");
        end
        run_txn(0, 1'b0, 32'h8, 32'h0, 1'b0, 0, 32'd0, cyc, err, rd);
        model_access(0, 1'b0, 32'h8, 32'h0, e_err, e_rd);
        checks++;
        if (err !== 1'b0 || rd !== e_rd) begin
            failures++;
            $display("FAIL abort_old_data rd=%h err=%b want rd=%h err=0", rd, err, e_rd);
        end
    endtask

    task automatic test_back_to_back(input int d);
        int          n, last, pulses;
        logic        e_err;
        logic [31:0] e_rd;
        @(negedge clk);
        req[d] = 1'b1;
        we[d]  = 1'b0;
        adr[d] = 32'h0;
        n = 0;
        last = 0;
        pulses = 0;
        while (pulses < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (rdy[d] === 1'b1) begin
                model_access(d, 1'b0, 32'h0, 32'h0, e_err, e_rd);
                if (pulses > 0) begin
                    checks++;
                    if (n - last != lat[d] + 3) begin
                        failures++;
                        $display("FAIL b2b_spacing dut%0d got=%0d want=%0d", d, n - last, lat[d] + 3);
                    end
                end
                checks++;
                if (rdata[d] !== e_rd || merr[d] !== e_err) begin
                    failures++;
                    $display("FAIL b2b_data dut%0d rd=%h err=%b want rd=%h err=%b",
                             d, rdata[d], merr[d], e_rd, e_err);
                end
                last = n;
                pulses++;
                if (pulses == 4) req[d] = 1'b0;
            end
        end
        req[d] = 1'b0;
        checks++;
        if (pulses != 4) begin
            failures++;
            $display("FAIL b2b_count dut%0d got=%0d want=4", d, pulses);
        end
    endtask

    task automatic test_init_collision();
        int          cyc;
        logic        err, e_err;
        logic [31:0] rd, e_rd;
        run_txn(0, 1'b0, 32'h2C, 32'h0, 1'b1, 11, 32'h0BADC0DE, cyc, err, rd);
        model_access(0, 1'b0, 32'h2C, 32'h0, e_err, e_rd);
        checks++;
        if (cyc != lat[0] + 2 || err !== 1'b0 || rd !== e_rd) begin
            failures++;
            $display("FAIL collide_req cyc=%0d rd=%h err=%b want cyc=%0d rd=%h err=0",
                     cyc, rd, err, lat[0] + 2, e_rd);
        end
        run_txn(0, 1'b0, 32'h2C, 32'h0, 1'b0, 0, 32'd0, cyc, err, rd);
        model_access(0, 1'b0, 32'h2C, 32'h0, e_err, e_rd);
        checks++;
        if (rd !== e_rd) begin
            failures++;
            $display("FAIL collide_dropped rd=%h want=%h", rd, e_rd);
        end
    endtask

    task automatic test_random(input int d);
        int          cyc, kind;
        bit          wr;
        logic        err, e_err;
        logic [31:0] a, wd, rd, e_rd;
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 9);
            wr   = 1'($urandom);
            wd   = $urandom;
            if (kind == 0)      a = (32'($urandom_range(0, NW - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (kind == 1) a = $urandom | 32'h100;
            else                a = 32'($urandom_range(0, NW - 1)) << 2;
            if (kind == 2) init_write(d, $urandom_range(0, NW - 1), $urandom);
            run_txn(d, wr, a, wd, 1'b0, 0, 32'd0, cyc, err, rd);
            model_access(d, wr, a, wd, e_err, e_rd);
            checks++;
            if (cyc != lat[d] + 2 || err !== e_err || rd !== e_rd) begin
                failures++;
                $display("FAIL rand dut%0d t=%0d wr=%0d adr=%h cyc=%0d err=%b rd=%h want cyc=%0d err=%b rd=%h",
                         d, t, wr, a, cyc, err, rd, lat[d] + 2, e_err, e_rd);
            end
        end
    endtask

    initial begin
        lat[0] = 2;
        lat[1] = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            req[d]       = 1'b0;
            we[d]        = 1'b0;
            adr[d]       = 32'd0;
            wdata[d]     = 32'd0;
            init_we[d]   = 1'b0;
            init_adr[d]  = '0;
            init_data[d] = 32'd0;
        end
        test_reset();
        preload();
        test_write_read();
        test_latency0();
        test_errors();
        test_reset_abort();
        test_back_to_back(0);
        test_back_to_back(1);
        test_init_collision();
        test_random(0);
        test_random(1);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
